// File: rtl/countdown_alarm_if.sv
// ----------------------------------------------------------------------------
// countdown_alarm_if
//
// Purpose: bundles the key inputs, the load value and the status outputs of
// the countdown timer. Clock and reset are kept outside the bundle.
//
// Signals:
//   load       key level, rising edge loads load_val
//   load_val   start value of the countdown, in ticks
//   start      key level, rising edge starts / resumes / cancels
//   pause      key level, rising edge pauses / resumes
//   count_act  high while the alarm phase is active (feeds the beeper)
//   remaining  current count value
//   busy       high while counting or paused
//   done       one-cycle pulse when the count expires
//
// Modports:
//   master  drives the keys and load value, observes the status
//   slave   the timer itself
// ----------------------------------------------------------------------------
interface countdown_alarm_if #(
   parameter int CNT_W = 8
);

   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             start;
   logic             pause;
   logic             count_act;
   logic [CNT_W-1:0] remaining;
   logic             busy;
   logic             done;

   modport master (
      output load, load_val, start, pause,
      input  count_act, remaining, busy, done
   );

   modport slave (
      input  load, load_val, start, pause,
      output count_act, remaining, busy, done
   );

endinterface

// File: rtl/countdown_alarm.sv
// ----------------------------------------------------------------------------
// countdown_alarm
//
// Purpose: loadable countdown timer. A prescaler produces one tick every
// TICK_CYCLES clocks; each tick in RUN decrements the count. When the count
// expires the block pulses done and holds count_act high for ALARM_TICKS
// ticks (the beeper's activate request), then falls back to IDLE.
// Key inputs are raw levels: each goes through a two-flop synchronizer, an
// optional debounce filter and a registered rising-edge detector.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous, active-high reset
//   bus   countdown_alarm_if.slave (load, load_val, start, pause in;
//         count_act, remaining, busy, done out, all registered)
//
// Build option:
//   COUNTDOWN_DEBOUNCE_EN  when defined, each synchronized key must differ
//                          from its filtered level for DB_CYCLES consecutive
//                          cycles before the filtered level follows it.
//                          When undefined, DB_CYCLES is unused.
// ----------------------------------------------------------------------------
module countdown_alarm #(
   parameter int TICK_CYCLES = 50_000_000,
   parameter int CNT_W       = 8,
   parameter int ALARM_TICKS = 3,
   parameter int DB_CYCLES   = 1_000_000
) (
   input  logic               clk,
   input  logic               rst,
   countdown_alarm_if.slave   bus
);

   localparam int PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int AlmW = $clog2(ALARM_TICKS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      ALARM = 2'd3
   } state_t;

   // Key vector ordering: bit 0 load, bit 1 start, bit 2 pause.
   logic [2:0] keyRaw;
   logic [2:0] keyMeta_q;
   logic [2:0] keySync_q;
   logic [2:0] keyLvl;
   logic [2:0] keyPrev_q;
   logic [2:0] keyEvt_q;

   logic loadEvt;
   logic startEvt;
   logic pauseEvt;

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  remaining_q;
   logic [CNT_W-1:0]  remaining_d;
   logic [PreW-1:0]   prescale_q;
   logic [PreW-1:0]   prescale_d;
   logic [AlmW-1:0]   alarmCnt_q;
   logic [AlmW-1:0]   alarmCnt_d;
   logic              tick;
   logic              doneNext;
   logic              countAct_q;
   logic              busy_q;
   logic              done_q;

   assign keyRaw = {bus.pause, bus.start, bus.load};

   // Two-flop synchronizer for the raw key levels, followed by a registered
   // rising-edge detector on whichever level the filter stage presents.
   // Registering the event gives a fixed three-cycle key-to-event latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         keyMeta_q <= '0;
         keySync_q <= '0;
         keyPrev_q <= '0;
         keyEvt_q  <= '0;
      end else begin
         keyMeta_q <= keyRaw;
         keySync_q <= keyMeta_q;
         keyPrev_q <= keyLvl;
         keyEvt_q  <= keyLvl & ~keyPrev_q;
      end
   end

`ifdef COUNTDOWN_DEBOUNCE_EN
   localparam int DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [2:0]     keyFilt_q;
   logic [DbW-1:0] dbCnt_q [3];

   // Debounce filter: the counter only advances while the synchronized level
   // disagrees with the filtered level, so any bounce back to agreement
   // restarts it. The filtered level flips on the DB_CYCLES-th disagreeing
   // cycle in a row.
   always_ff @(posedge clk) begin
      if (rst) begin
         keyFilt_q <= '0;
         for (int k = 0; k < 3; k++) begin
            dbCnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (keySync_q[k] == keyFilt_q[k]) begin
               dbCnt_q[k] <= '0;
            end else if (dbCnt_q[k] == DbW'(DB_CYCLES - 1)) begin
               keyFilt_q[k] <= keySync_q[k];
               dbCnt_q[k]   <= '0;
            end else begin
               dbCnt_q[k] <= dbCnt_q[k] + DbW'(1);
            end
         end
      end
   end

   assign keyLvl = keyFilt_q;
`else
   assign keyLvl = keySync_q;
`endif

   assign loadEvt  = keyEvt_q[0];
   assign startEvt = keyEvt_q[1];
   assign pauseEvt = keyEvt_q[2];

   // The prescaler's terminal count is the tick; it is only acted upon in
   // RUN and ALARM, where the prescaler is actually counting.
   assign tick = (prescale_q == PreW'(TICK_CYCLES - 1));

   // State register plus all counters and the registered outputs. The
   // status outputs are computed from the next state so that they change on
   // the same edge as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         prescale_q  <= '0;
         alarmCnt_q  <= '0;
         countAct_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         prescale_q  <= prescale_d;
         alarmCnt_q  <= alarmCnt_d;
         countAct_q  <= (state_d == ALARM);
         busy_q      <= (state_d == RUN) || (state_d == PAUSE);
         done_q      <= doneNext;
      end
   end

   // Next-state logic. In RUN, expiry outranks a simultaneous pause, and a
   // non-expiring tick is still applied before pausing. The prescaler keeps
   // its value across PAUSE so a resumed run finishes the interrupted tick
   // period instead of starting a fresh one. In IDLE the prescaler is held
   // at zero, which makes the first tick after a start a full period away.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      prescale_d  = prescale_q;
      alarmCnt_d  = alarmCnt_q;
      doneNext    = 1'b0;

      case (state_q)
         IDLE: begin
            prescale_d = '0;
            alarmCnt_d = '0;
            if (loadEvt) begin
               remaining_d = bus.load_val;
            end else if (startEvt && (remaining_q != '0)) begin
               state_d = RUN;
            end
         end

         RUN: begin
            prescale_d = tick ? '0 : prescale_q + PreW'(1);
            if (tick && (remaining_q <= CNT_W'(1))) begin
               remaining_d = '0;
               doneNext    = 1'b1;
               alarmCnt_d  = '0;
               state_d     = ALARM;
            end else begin
               if (tick) begin
                  remaining_d = remaining_q - CNT_W'(1);
               end
               if (pauseEvt) begin
                  state_d = PAUSE;
               end
            end
         end

         PAUSE: begin
            if (startEvt || pauseEvt) begin
               state_d = RUN;
            end
         end

         ALARM: begin
            prescale_d = tick ? '0 : prescale_q + PreW'(1);
            if (startEvt) begin
               state_d    = IDLE;
               prescale_d = '0;
               alarmCnt_d = '0;
            end else if (tick) begin
               if (alarmCnt_q == AlmW'(ALARM_TICKS - 1)) begin
                  state_d    = IDLE;
                  prescale_d = '0;
                  alarmCnt_d = '0;
               end else begin
                  alarmCnt_d = alarmCnt_q + AlmW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.count_act = countAct_q;
   assign bus.remaining = remaining_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_alarm.sv
// ----------------------------------------------------------------------------
// tb_countdown_alarm
//
// Purpose: directed, self-checking bench for countdown_alarm with
// TICK_CYCLES=10, ALARM_TICKS=3, DB_CYCLES=4. Inputs are driven and outputs
// sampled on the falling clock edge. COUNTDOWN_DEBOUNCE_EN selects which
// key-latency and bounce expectations apply.
// ----------------------------------------------------------------------------
module tb_countdown_alarm;

   localparam int TICK = 10;
   localparam int ALM  = 3;
   localparam int DB   = 4;
   localparam int CW   = 8;

`ifdef COUNTDOWN_DEBOUNCE_EN
   localparam int KEY_LAT = 4 + DB;
`else
   localparam int KEY_LAT = 4;
`endif
   localparam int KEY_HOLD = KEY_LAT - 2;

   logic clk = 1'b0;
   logic rst;

   int total = 0;
   int bad   = 0;

   countdown_alarm_if #(.CNT_W(CW)) bus ();

   countdown_alarm #(
      .TICK_CYCLES (TICK),
      .CNT_W       (CW),
      .ALARM_TICKS (ALM),
      .DB_CYCLES   (DB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends with a visible report.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presses the keys in 'keys' ({pause,start,load}) from the current falling
   // edge; returns KEY_LAT falling edges later, when the effect is visible.
   task automatic applyStimulus(input logic [2:0] keys);
      bus.pause = keys[2];
      bus.start = keys[1];
      bus.load  = keys[0];
      waitCycles(KEY_HOLD);
      bus.pause = 1'b0;
      bus.start = 1'b0;
      bus.load  = 1'b0;
      waitCycles(2);
   endtask

   task automatic doReset();
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      waitCycles(2);
   endtask

   // Linear directed sequence.
   initial begin
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.start    = 1'b0;
      bus.pause    = 1'b0;
      bus.load_val = '0;
      @(negedge clk);
      waitCycles(3);
      checkOutput("rst count_act", bus.count_act, 0);
      checkOutput("rst remaining", bus.remaining, 0);
      checkOutput("rst busy", bus.busy, 0);
      checkOutput("rst done", bus.done, 0);
      rst = 1'b0;
      waitCycles(2);

      // Full countdown from 5 through the alarm phase.
      bus.load_val = 8'd5;
      applyStimulus(3'b001);
      checkOutput("t1 loaded", bus.remaining, 5);
      checkOutput("t1 idle busy", bus.busy, 0);
      applyStimulus(3'b010);
      checkOutput("t1 busy", bus.busy, 1);
      checkOutput("t1 start rem", bus.remaining, 5);
      waitCycles(TICK - 1);
      checkOutput("t1 pre tick", bus.remaining, 5);
      waitCycles(1);
      checkOutput("t1 tick rem4", bus.remaining, 4);
      for (int r = 3; r >= 1; r--) begin
         waitCycles(TICK);
         checkOutput("t1 tick rem", bus.remaining, r);
      end
      waitCycles(TICK);
      checkOutput("t1 expire rem", bus.remaining, 0);
      checkOutput("t1 expire done", bus.done, 1);
      checkOutput("t1 expire act", bus.count_act, 1);
      checkOutput("t1 expire busy", bus.busy, 0);
      waitCycles(1);
      checkOutput("t1 done pulse", bus.done, 0);
      checkOutput("t1 act held", bus.count_act, 1);
      waitCycles(ALM * TICK - 2);
      checkOutput("t1 act last", bus.count_act, 1);
      waitCycles(1);
      checkOutput("t1 act off", bus.count_act, 0);
      checkOutput("t1 idle rem", bus.remaining, 0);
      checkOutput("t1 idle busy2", bus.busy, 0);

      // Pause 15 cycles into a run, hold, resume mid-period.
      bus.load_val = 8'd3;
      applyStimulus(3'b001);
      checkOutput("t2 loaded", bus.remaining, 3);
      applyStimulus(3'b010);
      waitCycles(15 - KEY_LAT);
      applyStimulus(3'b100);
      checkOutput("t2 paused rem", bus.remaining, 2);
      checkOutput("t2 paused busy", bus.busy, 1);
      waitCycles(50);
      checkOutput("t2 frozen rem", bus.remaining, 2);
      checkOutput("t2 frozen act", bus.count_act, 0);
      applyStimulus(3'b010);
      checkOutput("t2 resumed", bus.remaining, 2);
      waitCycles(4);
      checkOutput("t2 pre tick", bus.remaining, 2);
      waitCycles(1);
      checkOutput("t2 resume tick", bus.remaining, 1);
      waitCycles(TICK);
      checkOutput("t2 expire done", bus.done, 1);
      waitCycles(ALM * TICK);
      checkOutput("t2 act off", bus.count_act, 0);

      // Start with a zero count is ignored.
      applyStimulus(3'b010);
      checkOutput("t3 busy", bus.busy, 0);
      checkOutput("t3 act", bus.count_act, 0);
      waitCycles(TICK);
      checkOutput("t3 still idle", bus.busy, 0);

      // Cancel during ALARM with a start press.
      bus.load_val = 8'd1;
      applyStimulus(3'b001);
      applyStimulus(3'b010);
      waitCycles(TICK);
      checkOutput("t4 alarm", bus.count_act, 1);
      bus.start = 1'b1;
      waitCycles(KEY_LAT - 1);
      checkOutput("t4 not early", bus.count_act, 1);
      waitCycles(1);
      checkOutput("t4 cancelled", bus.count_act, 0);
      checkOutput("t4 cancel busy", bus.busy, 0);
      bus.start = 1'b0;
      waitCycles(TICK);

      // Reset in the middle of a run.
      bus.load_val = 8'd5;
      applyStimulus(3'b001);
      applyStimulus(3'b010);
      waitCycles(TICK + 2);
      checkOutput("t4 run rem", bus.remaining, 4);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("t4 rst act", bus.count_act, 0);
      checkOutput("t4 rst rem", bus.remaining, 0);
      checkOutput("t4 rst busy", bus.busy, 0);
      checkOutput("t4 rst done", bus.done, 0);
      rst = 1'b0;
      waitCycles(TICK + 2);
      checkOutput("t4 post rst busy", bus.busy, 0);

      // Load and start in the same cycle: load wins.
      bus.load_val = 8'd7;
      applyStimulus(3'b011);
      checkOutput("t5 rem", bus.remaining, 7);
      checkOutput("t5 busy", bus.busy, 0);
      waitCycles(TICK + 2);
      checkOutput("t5 still idle", bus.busy, 0);
      checkOutput("t5 rem held", bus.remaining, 7);
      doReset();

      // Bouncing key: toggle every 2 cycles for 20 cycles, then hold high.
      // Each rise carries its own load value so separate events are visible.
      for (int k = 1; k <= 5; k++) begin
         bus.load_val = CW'(k);
         bus.load     = 1'b1;
         waitCycles(2);
         bus.load     = 1'b0;
         waitCycles(2);
`ifdef COUNTDOWN_DEBOUNCE_EN
         checkOutput("t6 bounce filtered", bus.remaining, 0);
`else
         checkOutput("t6 bounce event", bus.remaining, k);
`endif
      end
      bus.load_val = 8'd42;
      bus.load     = 1'b1;
      waitCycles(KEY_LAT - 1);
`ifdef COUNTDOWN_DEBOUNCE_EN
      checkOutput("t6 hold early", bus.remaining, 0);
`else
      checkOutput("t6 hold early", bus.remaining, 5);
`endif
      waitCycles(1);
      checkOutput("t6 hold event", bus.remaining, 42);
      bus.load = 1'b0;
      waitCycles(KEY_LAT + 4);
      checkOutput("t6 no extra", bus.remaining, 42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
